data_upload: RTL and testbench

SPI transmitter that streams a RAM region back to the MiST IO controller, so the core can upload data (save files, memory dumps) in the opposite direction to the file download path. It sits between the IO controller SPI pins and a RAM read port: it decodes the upload commands, prefetches bytes from RAM and shifts them out on `sdo`. The block is fully synchronous to `clk`. SPI inputs are oversampled, and `clk` must be at least 8x the `sck` frequency.

---
 rtl/data_upload.sv | 148 ++++++++++++++
 tb/tb_data_upload.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_upload.sv
// SPI upload transmitter: decodes the upload commands from the IO controller,
// prefetches bytes from a RAM read port and shifts them out MSB first on sdo.
module data_upload #(
  parameter logic [24:0] START_ADDR = 25'h0000000,
  parameter logic [7:0]  CMD_RX     = 8'h56,
  parameter logic [7:0]  CMD_RX_DAT = 8'h57
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  output logic        uploading,
  output logic        underrun,
  output logic        rd,
  output logic [24:0] addr,
  input  logic [7:0]  din,
  input  logic        din_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_e;

  fetch_state_e state, state_next;

  logic [2:0] sck_sync;
  logic [1:0] ss_sync;
  logic [1:0] sdi_sync;
  logic       sck_rise, sck_fall, ss_s, sdi_s;

  logic [3:0] cnt;
  logic [6:0] sbuf;
  logic [7:0] cmd;
  logic [7:0] tx;
  logic [7:0] pbuf;
  logic       sdo_r;

  logic rx_evt, cmd_start, cmd_end, byte_load, byte_shift;

  // Oversampled SPI inputs; ss powers up deselected so nothing decodes early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= 3'b000;
      ss_sync  <= 2'b11;
      sdi_sync <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value, which is what turns these into a real shift chain.
      sck_sync <= {sck_sync[1:0], sck};
      ss_sync  <= {ss_sync[0], ss};
      sdi_sync <= {sdi_sync[0], sdi};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign ss_s     = ss_sync[1];
  assign sdi_s    = sdi_sync[1];

  assign rx_evt     = sck_rise & ~ss_s;
  assign cmd_start  = rx_evt && (cnt == 4'd15) && (cmd == CMD_RX) && sdi_s;
  assign cmd_end    = rx_evt && (cnt == 4'd15) && (cmd == CMD_RX) && !sdi_s;
  assign byte_load  = sck_fall && !ss_s && (cnt == 4'd8) && (cmd == CMD_RX_DAT) && uploading;
  assign byte_shift = sck_fall && !ss_s && (cnt >= 4'd9) && (cmd == CMD_RX_DAT) && uploading;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every path must assign state_next; the default-first hold keeps
    // this block purely combinational instead of inferring a latch.
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_IDLE;
      S_REQ:   state_next = S_WAIT;
      S_WAIT:  if (din_valid) state_next = S_FULL;
      S_FULL:  if (byte_load) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
    // Start/end commands win over whatever the fetch was doing.
    if (cmd_start)    state_next = S_REQ;
    else if (cmd_end) state_next = S_IDLE;
  end

  assign rd = (state == S_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pbuf <= 8'h00;
    else if (state == S_WAIT && state_next == S_FULL) pbuf <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      sbuf      <= 7'd0;
      cmd       <= 8'h00;
      tx        <= 8'h00;
      sdo_r     <= 1'b0;
      uploading <= 1'b0;
      underrun  <= 1'b0;
      addr      <= START_ADDR;
    end else begin
      if (ss_s)          cnt <= 4'd0;
      else if (sck_rise) cnt <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;

      if (rx_evt) begin
        sbuf <= {sbuf[5:0], sdi_s};
        if (cnt == 4'd7) cmd <= {sbuf, sdi_s};
      end

      if (cmd_start) begin
        addr      <= START_ADDR;
        uploading <= 1'b1;
        underrun  <= 1'b0;
      end else if (cmd_end) begin
        uploading <= 1'b0;
      end

      // An unready prefetch sends 0xFF and leaves the fetch pending for the next byte.
      if (ss_s) begin
        sdo_r <= 1'b0;
      end else if (byte_load) begin
        if (state == S_FULL) begin
          tx    <= pbuf;
          sdo_r <= pbuf[7];
          addr  <= addr + 25'd1;
        end else begin
          tx       <= 8'hFF;
          sdo_r    <= 1'b1;
          underrun <= 1'b1;
        end
      end else if (byte_shift) begin
        tx    <= {tx[6:0], 1'b0};
        sdo_r <= tx[6];
      end
    end
  end

  assign sdo = sdo_r & (cmd == CMD_RX_DAT);

endmodule

// File: tb/tb_data_upload.sv
// Bench for data_upload: two instances (base 0 and base 1FFFFFF) share one SPI
// master and each has its own latency-programmable RAM responder.
module tb_data_upload;

  localparam logic [24:0] BASE0 = 25'h0000000;
  localparam logic [24:0] BASE1 = 25'h1FFFFFF;
  localparam int          SLACK = 8;

  logic clk = 1'b0;
  logic reset, sck, ss, sdi;
  logic sdo0, up0, und0, rd0, sdo1, up1, und1, rd1;
  logic [24:0] addr0, addr1;
  logic [7:0] din_q [2];
  logic       dv_q  [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 2;
  int half = 4;
  int rise_cyc = 0;
  int dv_cnt [2];

  logic [7:0]  mem [256];
  logic [24:0] log0 [$];
  logic [24:0] log1 [$];

  typedef struct {
    bit          up;
    logic [24:0] addr;
    logic [24:0] base;
    int          ready;
    bit          und;
  } model_t;
  model_t m [2];

  data_upload dut0 (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi), .sdo(sdo0),
    .uploading(up0), .underrun(und0), .rd(rd0), .addr(addr0),
    .din(din_q[0]), .din_valid(dv_q[0])
  );

  data_upload #(.START_ADDR(BASE1)) dut1 (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi), .sdo(sdo1),
    .uploading(up1), .underrun(und1), .rd(rd1), .addr(addr1),
    .din(din_q[1]), .din_valid(dv_q[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM responders: answer each rd after lat cycles with a one-cycle din_valid.
  bit          pend      [2];
  int          pend_cnt  [2];
  logic [24:0] pend_addr [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      dv_q[k] = 1'b0;
      if (pend[k]) begin
        pend_cnt[k]--;
        if (pend_cnt[k] == 0) begin
          din_q[k] = mem[pend_addr[k][7:0]];
          dv_q[k]  = 1'b1;
          pend[k]  = 1'b0;
          dv_cnt[k]++;
        end
      end
      if ((k == 0) ? rd0 : rd1) begin
        pend[k]      = 1'b1;
        pend_cnt[k]  = lat;
        pend_addr[k] = (k == 0) ? addr0 : addr1;
        if (k == 0) log0.push_back(addr0);
        else        log1.push_back(addr1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a byte load returns RAM[addr] if the fetch issued at the
  // previous start/load has had lat cycles (plus sync slack), else 0xFF.
  function automatic logic [7:0] m_load(input int k, input int c);
    logic [7:0] v;
    if (!m[k].up) return 8'h00;
    if (c >= m[k].ready) begin
      v          = mem[m[k].addr[7:0]];
      m[k].addr  = m[k].addr + 25'd1;
      m[k].ready = c + lat + SLACK;
    end else begin
      v         = 8'hFF;
      m[k].und  = 1'b1;
    end
    return v;
  endfunction

  task automatic sel();
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic desel();
    ss  = 1'b1;
    sdi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Mode-0 master: sdi set on the falling edge, sdo sampled just before the rise.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit drop_ss,
                          output logic [7:0] r0, output logic [7:0] r1);
    r0 = 8'h00;
    r1 = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = b[i];
      repeat (half) @(negedge clk);
      r0[i] = sdo0;
      r1[i] = sdo1;
      sck = 1'b1;
      rise_cyc = cyc;
      repeat (half) @(negedge clk);
      if (drop_ss && i == 8 - nbits) ss = 1'b1;
      sck = 1'b0;
    end
  endtask

  task automatic cmd_rx(input bit go);
    logic [7:0] r0, r1;
    sel();
    spi_bits(8'h56, 8, 1'b0, r0, r1);
    spi_bits({7'b0, go}, 8, 1'b1, r0, r1);
    for (int k = 0; k < 2; k++) begin
      if (go) begin
        m[k].up    = 1'b1;
        m[k].addr  = m[k].base;
        m[k].und   = 1'b0;
        m[k].ready = rise_cyc + lat + SLACK;
      end else begin
        m[k].up = 1'b0;
      end
    end
    desel();
  endtask

  task automatic read_data(input int n);
    logic [7:0] r0, r1, e0, e1;
    sel();
    spi_bits(8'h57, 8, 1'b0, r0, r1);
    e0 = m_load(0, cyc);
    e1 = m_load(1, cyc);
    for (int b = 1; b <= n; b++) begin
      spi_bits(8'h00, 8, b == n, r0, r1);
      check($sformatf("byte%0d_base0", b), {24'h0, r0}, {24'h0, e0});
      check($sformatf("byte%0d_base1", b), {24'h0, r1}, {24'h0, e1});
      if (b < n) begin
        e0 = m_load(0, cyc);
        e1 = m_load(1, cyc);
      end
    end
    desel();
  endtask

  initial begin
    logic [7:0] r0, r1, e0, e1;
    int n_rd, d0;
    logic [24:0] ea;

    reset = 1'b1; sck = 1'b0; ss = 1'b1; sdi = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
    m[0] = '{up: 1'b0, addr: BASE0, base: BASE0, ready: 0, und: 1'b0};
    m[1] = '{up: 1'b0, addr: BASE1, base: BASE1, ready: 0, und: 1'b0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_sdo", {31'h0, sdo0}, 32'h0);
    check("rst_uploading", {31'h0, up0}, 32'h0);
    check("rst_underrun", {31'h0, und0}, 32'h0);
    check("rst_rd", {31'h0, rd0}, 32'h0);
    check("rst_addr0", {7'h0, addr0}, {7'h0, BASE0});
    check("rst_addr1", {7'h0, addr1}, {7'h0, BASE1});

    // Start and stream three bytes with 2-cycle RAM latency; also covers address wrap.
    lat = 2;
    log0.delete(); log1.delete();
    cmd_rx(1'b1);
    check("start_uploading", {31'h0, up0}, {31'h0, m[0].up});
    read_data(3);
    check("stream_addr0", {7'h0, addr0}, 32'd3);
    check("stream_underrun", {31'h0, und0}, 32'h0);
    check("rdlog0_size", log0.size(), 32'd4);
    check("rdlog1_size", log1.size(), 32'd4);
    for (int i = 0; i < 4 && i < log0.size(); i++) begin
      ea = BASE0 + 25'(i);
      check($sformatf("rdlog0_%0d", i), {7'h0, log0[i]}, {7'h0, ea});
    end
    for (int i = 0; i < 4 && i < log1.size(); i++) begin
      ea = BASE1 + 25'(i);
      check($sformatf("rdlog1_%0d", i), {7'h0, log1[i]}, {7'h0, ea});
    end

    // Underrun: RAM far slower than one byte time.
    lat = 200;
    cmd_rx(1'b1);
    read_data(1);
    check("underrun_set", {31'h0, und0}, {31'h0, m[0].und});
    repeat (300) @(negedge clk);
    read_data(1);
    check("underrun_sticky", {31'h0, und0}, {31'h0, m[0].und});

    // End while the fetch is outstanding: the late din_valid must be ignored.
    cmd_rx(1'b1);
    cmd_rx(1'b0);
    check("end_uploading", {31'h0, up0}, 32'h0);
    n_rd = log0.size();
    d0   = dv_cnt[0];
    repeat (150) @(negedge clk);
    check("end_dv_arrived", dv_cnt[0], d0 + 1);
    check("end_rd_quiet", log0.size(), n_rd);
    check("end_still_idle", {31'h0, up0}, 32'h0);
    read_data(1);

    // Asynchronous reset during bit 4 of a data byte.
    lat = 2;
    cmd_rx(1'b1);
    sel();
    spi_bits(8'h57, 8, 1'b0, r0, r1);
    e0 = m_load(0, cyc);
    e1 = m_load(1, cyc);
    spi_bits(8'h00, 4, 1'b0, r0, r1);
    check("pre_reset_uploading", {31'h0, up0}, {31'h0, m[0].up});
    sdi = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_sdo", {31'h0, sdo0}, 32'h0);
    check("arst_uploading", {31'h0, up0}, 32'h0);
    check("arst_underrun", {31'h0, und0}, 32'h0);
    check("arst_rd", {31'h0, rd0}, 32'h0);
    check("arst_addr0", {7'h0, addr0}, {7'h0, BASE0});
    check("arst_addr1", {7'h0, addr1}, {7'h0, BASE1});
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m[k].up   = 1'b0;
      m[k].und  = 1'b0;
      m[k].addr = m[k].base;
    end
    desel();
    cmd_rx(1'b1);
    check("post_reset_uploading", {31'h0, up0}, 32'h1);
    read_data(2);

    // Deselect after three data bits, then reselect for the following byte.
    sel();
    spi_bits(8'h57, 8, 1'b0, r0, r1);
    e0 = m_load(0, cyc);
    e1 = m_load(1, cyc);
    spi_bits(8'h00, 3, 1'b1, r0, r1);
    desel();
    check("desel_uploading", {31'h0, up0}, 32'h1);
    read_data(1);

    // Randomised uploads: random RAM contents, latency, sck rate and length.
    for (int it = 0; it < 3; it++) begin
      lat  = $urandom_range(1, 20);
      half = $urandom_range(4, 6);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      cmd_rx(1'b1);
      check($sformatf("rand%0d_uploading", it), {31'h0, up0}, 32'h1);
      read_data($urandom_range(1, 4));
      check($sformatf("rand%0d_underrun", it), {31'h0, und0}, {31'h0, m[0].und});
    end
    cmd_rx(1'b0);
    check("final_uploading", {31'h0, up1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
